alu_arbiter: RTL and testbench

- Shares the single combinational 8-bit ALU between two requesters: core execute path (port 0) and debug/DMA side path (port 1).
- Accepts one operation at a time through a valid/ready handshake, using round-robin arbitration.
- Drives the ALU OP/inA/inB from registered operands and captures rslt/neg/zero into a response register.
- Returns the response to the granted requester through a valid/ready handshake that supports backpressure.

---
 rtl/alu_arbiter.sv | 230 +++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters (port 0: core
//   execute path, port 1: debug/DMA side path). One operation is in flight at a
//   time: IDLE accepts a request with round-robin priority, EXEC lets the ALU
//   evaluate the registered operands, RESP presents the captured result to the
//   owning requester until it is consumed.
//
// Ports
//   clk, rst_n                       clock (rising edge), async active-low reset
//   reqN_valid/ready/op/a/b          operation request handshake, N = 0/1
//   rspN_valid/ready/rslt/neg/zero   response handshake with backpressure
//   alu_op/alu_a/alu_b               registered operands to the ALU
//   alu_rslt/alu_neg/alu_zero        ALU result and flags, captured in EXEC
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [OPW-1:0] req0_op,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [DW-1:0]  rsp0_rslt,
    output logic           rsp0_neg,
    output logic           rsp0_zero,

    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [OPW-1:0] req1_op,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [DW-1:0]  rsp1_rslt,
    output logic           rsp1_neg,
    output logic           rsp1_zero,

    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_rslt,
    input  logic           alu_neg,
    input  logic           alu_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;

    logic [OPW-1:0]  op_r;
    logic [DW-1:0]   a_r;
    logic [DW-1:0]   b_r;
    logic            owner_r;
    logic            last_grant_r;

    logic            rsp0_valid_r;
    logic [DW-1:0]   rsp0_rslt_r;
    logic            rsp0_neg_r;
    logic            rsp0_zero_r;
    logic            rsp1_valid_r;
    logic [DW-1:0]   rsp1_rslt_r;
    logic            rsp1_neg_r;
    logic            rsp1_zero_r;

    logic            any_req_s;
    logic            winner_s;
    logic            accept_s;
    logic            rsp_ack_s;
    logic [OPW-1:0]  sel_op_s;
    logic [DW-1:0]   sel_a_s;
    logic [DW-1:0]   sel_b_s;

    assign any_req_s = req0_valid | req1_valid;

    // Round-robin winner: on a tie the requester that was not granted last wins
    always_comb begin
        winner_s = 1'b0;
        if (req0_valid && req1_valid) begin
            winner_s = ~last_grant_r;
        end else if (req1_valid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    // rst_n is folded in so both readies read 0 while reset is held
    assign accept_s   = rst_n & (state_r == ST_IDLE) & any_req_s;
    assign req0_ready = accept_s & ~winner_s;
    assign req1_ready = accept_s & winner_s;

    // Operand select of the winning requester
    always_comb begin
        sel_op_s = req0_op;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (winner_s) begin
            sel_op_s = req1_op;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_op;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // Consume indication from the requester that owns the pending response
    always_comb begin
        rsp_ack_s = 1'b0;
        if (owner_r) begin
            rsp_ack_s = rsp1_ready;
        end else begin
            rsp_ack_s = rsp0_ready;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ack_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Issue registers and arbitration history, loaded in the accept cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= {OPW{1'b0}};
            a_r          <= {DW{1'b0}};
            b_r          <= {DW{1'b0}};
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
        end else if (accept_s) begin
            op_r         <= sel_op_s;
            a_r          <= sel_a_s;
            b_r          <= sel_b_s;
            owner_r      <= winner_s;
            last_grant_r <= winner_s;
        end
    end

    // Port 0 response register: capture in EXEC, release on consume in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_r <= 1'b0;
            rsp0_rslt_r  <= {DW{1'b0}};
            rsp0_neg_r   <= 1'b0;
            rsp0_zero_r  <= 1'b0;
        end else if ((state_r == ST_EXEC) && (owner_r == 1'b0)) begin
            rsp0_valid_r <= 1'b1;
            rsp0_rslt_r  <= alu_rslt;
            rsp0_neg_r   <= alu_neg;
            rsp0_zero_r  <= alu_zero;
        end else if ((state_r == ST_RESP) && (owner_r == 1'b0) && rsp0_ready) begin
            rsp0_valid_r <= 1'b0;
        end
    end

    // Port 1 response register: capture in EXEC, release on consume in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid_r <= 1'b0;
            rsp1_rslt_r  <= {DW{1'b0}};
            rsp1_neg_r   <= 1'b0;
            rsp1_zero_r  <= 1'b0;
        end else if ((state_r == ST_EXEC) && (owner_r == 1'b1)) begin
            rsp1_valid_r <= 1'b1;
            rsp1_rslt_r  <= alu_rslt;
            rsp1_neg_r   <= alu_neg;
            rsp1_zero_r  <= alu_zero;
        end else if ((state_r == ST_RESP) && (owner_r == 1'b1) && rsp1_ready) begin
            rsp1_valid_r <= 1'b0;
        end
    end

    assign alu_op     = op_r;
    assign alu_a      = a_r;
    assign alu_b      = b_r;

    assign rsp0_valid = rsp0_valid_r;
    assign rsp0_rslt  = rsp0_rslt_r;
    assign rsp0_neg   = rsp0_neg_r;
    assign rsp0_zero  = rsp0_zero_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp1_rslt  = rsp1_rslt_r;
    assign rsp1_neg   = rsp1_neg_r;
    assign rsp1_zero  = rsp1_zero_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//   Bench for alu_arbiter. Provides a stand-in 8-bit ALU, keeps a
//   transaction-level model of the arbiter (one pending operation, its owner,
//   whether its result has been produced, per-port response contents) and
//   compares every DUT output against it on each falling edge. Directed
//   sequences pin the model with hand-computed literals; a randomized phase
//   follows.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_op, req1_op;
    logic [7:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp0_rslt, rsp1_rslt;
    logic       rsp0_neg, rsp0_zero, rsp1_neg, rsp1_zero;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_rslt;
    logic       alu_neg, alu_zero;
    logic [9:0] alu_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    // Stand-in ALU; returns {neg, zero, rslt}
    function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        logic       n, z;
        r = 8'h00;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a & ~b;
            4'd4:  r = a ^ b;
            4'd5:  r = {a[7], a[7:1]};
            4'd8:  r = {a[6:0], 1'b0};
            4'd9:  r = {1'b0, a[7:1]};
            4'd10: r = ~a;
            4'd11: r = b;
            4'd12: r = a + 8'd1;
            4'd13: r = a - 8'd1;
            4'd14: r = a | b;
            4'd15: r = ~(a & b);
            default: r = 8'h00;
        endcase
        n = r[7];
        z = (r == 8'h00);
        if (op == 4'd6) begin
            n = ($signed(a) < $signed(b));
            z = (a == b);
        end
        if (op == 4'd7) begin
            n = (a < b);
            z = (a == b);
        end
        return {n, z, r};
    endfunction

    assign alu_out  = alu_fn(alu_op, alu_a, alu_b);
    assign alu_rslt = alu_out[7:0];
    assign alu_zero = alu_out[8];
    assign alu_neg  = alu_out[9];

    alu_arbiter #(.DW(8), .OPW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rslt(rsp0_rslt),
        .rsp0_neg(rsp0_neg), .rsp0_zero(rsp0_zero),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rslt(rsp1_rslt),
        .rsp1_neg(rsp1_neg), .rsp1_zero(rsp1_zero),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_rslt(alu_rslt), .alu_neg(alu_neg), .alu_zero(alu_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: tie goes to the port not granted last
    function automatic bit pick(input bit v0, input bit v1, input bit last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_busy, m_done, m_port, m_last;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic [9:0] m_data [2];

    // Transaction model: accept -> produce result -> wait for consume
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_port <= 1'b0; m_last <= 1'b1;
            m_op <= 4'h0; m_a <= 8'h00; m_b <= 8'h00;
            m_data[0] <= 10'h000; m_data[1] <= 10'h000;
        end else if (!m_busy) begin
            if (req0_valid || req1_valid) begin
                m_busy <= 1'b1;
                m_done <= 1'b0;
                m_port <= pick(req0_valid, req1_valid, m_last);
                m_last <= pick(req0_valid, req1_valid, m_last);
                m_op   <= pick(req0_valid, req1_valid, m_last) ? req1_op : req0_op;
                m_a    <= pick(req0_valid, req1_valid, m_last) ? req1_a  : req0_a;
                m_b    <= pick(req0_valid, req1_valid, m_last) ? req1_b  : req0_b;
            end
        end else if (!m_done) begin
            m_done         <= 1'b1;
            m_data[m_port] <= alu_fn(m_op, m_a, m_b);
        end else if (m_port ? rsp1_ready : rsp0_ready) begin
            m_busy <= 1'b0;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            bit w;
            w = pick(req0_valid, req1_valid, m_last);
            check("req0_ready", 32'(req0_ready), 32'(rst_n && !m_busy && req0_valid && !w));
            check("req1_ready", 32'(req1_ready), 32'(rst_n && !m_busy && req1_valid && w));
            check("alu_op", 32'(alu_op), 32'(m_op));
            check("alu_a", 32'(alu_a), 32'(m_a));
            check("alu_b", 32'(alu_b), 32'(m_b));
            check("rsp0_valid", 32'(rsp0_valid), 32'(m_busy && m_done && !m_port));
            check("rsp1_valid", 32'(rsp1_valid), 32'(m_busy && m_done && m_port));
            check("rsp0_data", 32'({rsp0_neg, rsp0_zero, rsp0_rslt}), 32'(m_data[0]));
            check("rsp1_data", 32'({rsp1_neg, rsp1_zero, rsp1_rslt}), 32'(m_data[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit p, input bit v, input logic [3:0] op,
                           input logic [7:0] a, input logic [7:0] b);
        if (p) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Waits (bounded) for the port's ready; returns just after the accept edge
    task automatic wait_ready(input bit p);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_ready_timeout", 32'(got), 32'h1);
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the port's response and checks literal contents
    task automatic wait_rsp(input bit p, input logic [7:0] er, input bit en, input bit ez);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (p ? rsp1_valid : rsp0_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("wait_rsp_timeout", 32'(got), 32'h1);
        if (p) begin
            check("rsp1_lit", 32'({rsp1_neg, rsp1_zero, rsp1_rslt}), 32'({en, ez, er}));
        end else begin
            check("rsp0_lit", 32'({rsp0_neg, rsp0_zero, rsp0_rslt}), 32'({en, ez, er}));
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        bit acc0, acc1;
        rst_n = 1'b1;
        set_req(1'b0, 1'b0, 4'h0, 8'h00, 8'h00);
        set_req(1'b1, 1'b0, 4'h0, 8'h00, 8'h00);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1 cmp_en = 1'b1;

        // Reset release with a waiting add on port 0
        set_req(1'b0, 1'b1, 4'h0, 8'h05, 8'h03);
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'h0);
        check("rst_alu", 32'({alu_op, alu_a, alu_b}), 32'h0);
        #1 rst_n = 1'b1;
        #1;
        check("t1_ready0_c0", 32'(req0_ready), 32'h1);
        check("t1_ready1_c0", 32'(req1_ready), 32'h0);
        @(posedge clk);
        #1 set_req(1'b0, 1'b0, 4'h0, 8'h05, 8'h03);
        @(negedge clk);
        check("t1_alu_c1", 32'({alu_op, alu_a, alu_b}), 32'h00503);
        check("t1_rsp0_valid_c1", 32'(rsp0_valid), 32'h0);
        @(negedge clk);
        check("t1_rsp0_valid_c2", 32'(rsp0_valid), 32'h1);
        check("t1_rsp0_c2", 32'({rsp0_neg, rsp0_zero, rsp0_rslt}), 32'h008);
        check("t1_rsp1_valid_c2", 32'(rsp1_valid), 32'h0);

        // Tie after reset: port 0 first, then a repeated tie goes to port 1
        do_reset();
        set_req(1'b0, 1'b1, 4'h1, 8'h10, 8'h01);
        set_req(1'b1, 1'b1, 4'hE, 8'hF0, 8'h0F);
        #1;
        check("t2_tie_ready0", 32'(req0_ready), 32'h1);
        check("t2_tie_ready1", 32'(req1_ready), 32'h0);
        @(posedge clk);
        #1 set_req(1'b0, 1'b1, 4'h2, 8'h3C, 8'h0F);
        wait_rsp(1'b0, 8'h0F, 1'b0, 1'b0);
        @(negedge clk);
        check("t3_tie_ready1", 32'(req1_ready), 32'h1);
        check("t3_tie_ready0", 32'(req0_ready), 32'h0);
        @(posedge clk);
        #1 set_req(1'b1, 1'b0, 4'hE, 8'hF0, 8'h0F);
        wait_rsp(1'b1, 8'hFF, 1'b1, 1'b0);
        wait_ready(1'b0);
        set_req(1'b0, 1'b0, 4'h2, 8'h3C, 8'h0F);
        wait_rsp(1'b0, 8'h0C, 1'b0, 1'b0);

        // Compare ops on port 1
        @(posedge clk);
        #1 set_req(1'b1, 1'b1, 4'h6, 8'h03, 8'h07);
        wait_ready(1'b1);
        set_req(1'b1, 1'b0, 4'h6, 8'h03, 8'h07);
        wait_rsp(1'b1, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1 set_req(1'b1, 1'b1, 4'h7, 8'h07, 8'h07);
        wait_ready(1'b1);
        set_req(1'b1, 1'b0, 4'h7, 8'h07, 8'h07);
        wait_rsp(1'b1, 8'h00, 1'b0, 1'b1);

        // Backpressure on port 0 while port 1 keeps requesting
        @(posedge clk);
        #1 rsp0_ready = 1'b0;
        set_req(1'b0, 1'b1, 4'h5, 8'h80, 8'h01);
        set_req(1'b1, 1'b1, 4'h4, 8'hAA, 8'h55);
        #1;
        check("t5_ready0", 32'(req0_ready), 32'h1);
        @(posedge clk);
        #1 set_req(1'b0, 1'b0, 4'h5, 8'h80, 8'h01);
        wait_rsp(1'b0, 8'hC0, 1'b1, 1'b0);
        check("t5_hold_ready1", 32'(req1_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(rsp0_valid), 32'h1);
            check("t5_hold_rslt", 32'(rsp0_rslt), 32'hC0);
            check("t5_hold_ready1", 32'(req1_ready), 32'h0);
        end
        @(posedge clk);
        #1 rsp0_ready = 1'b1;
        @(negedge clk);
        check("t5_last_valid", 32'(rsp0_valid), 32'h1);
        check("t5_last_ready1", 32'(req1_ready), 32'h0);
        @(negedge clk);
        check("t5_idle_ready1", 32'(req1_ready), 32'h1);
        @(posedge clk);
        #1 set_req(1'b1, 1'b0, 4'h4, 8'hAA, 8'h55);
        wait_rsp(1'b1, 8'hFF, 1'b1, 1'b0);

        // Reset in the middle of EXEC
        @(posedge clk);
        #1 set_req(1'b0, 1'b1, 4'h0, 8'hFF, 8'h01);
        wait_ready(1'b0);
        set_req(1'b0, 1'b0, 4'h0, 8'hFF, 8'h01);
        #2 rst_n = 1'b0;
        #1;
        check("t6_flags", 32'({rsp0_valid, rsp1_valid, rsp0_neg, rsp0_zero, rsp1_neg,
                                rsp1_zero, req0_ready, req1_ready}), 32'h0);
        check("t6_rslt", 32'({rsp0_rslt, rsp1_rslt}), 32'h0);
        check("t6_alu", 32'({alu_op, alu_a, alu_b}), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_no_rsp0", 32'(rsp0_valid), 32'h0);
        end
        @(posedge clk);
        #1 set_req(1'b0, 1'b1, 4'h0, 8'h01, 8'h02);
        set_req(1'b1, 1'b1, 4'h9, 8'h81, 8'h00);
        #1;
        check("t6_tie_ready0", 32'(req0_ready), 32'h1);
        check("t6_tie_ready1", 32'(req1_ready), 32'h0);
        @(posedge clk);
        #1 set_req(1'b0, 1'b0, 4'h0, 8'h01, 8'h02);
        wait_rsp(1'b0, 8'h03, 1'b0, 1'b0);
        wait_ready(1'b1);
        set_req(1'b1, 1'b0, 4'h9, 8'h81, 8'h00);
        wait_rsp(1'b1, 8'h40, 1'b0, 1'b0);

        // Randomized traffic with backpressure, withdrawals and rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk);
            #1;
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            if (req0_valid && !acc0) begin
                if ($urandom_range(0, 9) == 0) req0_valid = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_req(1'b0, 1'b1, 4'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                req0_valid = 1'b0;
            end
            if (req1_valid && !acc1) begin
                if ($urandom_range(0, 9) == 0) req1_valid = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                set_req(1'b1, 1'b1, 4'($urandom), 8'($urandom), 8'($urandom));
            end else begin
                req1_valid = 1'b0;
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
